spi_wb_loader: RTL and testbench



---
 rtl/spi_wb_loader_pkg.sv | 21 ++
 rtl/spi_wb_loader_if.sv | 22 ++
 rtl/spi_rx_sync.sv | 61 ++++++
 rtl/spi_wb_loader.sv | 187 ++++++++++++++++++
 tb/tb_spi_wb_loader.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_wb_loader_pkg.sv
// Shared definitions for the SPI-to-Wishbone loader: command codes and FSM state types.
package bk_pkg;

  localparam logic [7:0] CMD_WR_WORD = 8'h01;
  localparam logic [7:0] CMD_WR_BYTE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ALO,
    S_AHI,
    S_DATA,
    S_SKIP
  } parse_state_e;

  typedef enum logic [0:0] {
    B_IDLE,
    B_WAIT
  } bus_state_e;

endpackage

// File: rtl/spi_wb_loader_if.sv
// Wishbone write-only initiator bundle between the loader and the memory/register slaves.
interface spi_wb_loader_if;
  // Handshake: while wb_stb=1 the initiator holds wb_adr/wb_dat_o/wb_sel stable; the
  // transfer completes on the rising edge where the slave drives wb_ack=1.
  logic [15:0] wb_adr;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic        wb_ack;

  modport master (
    output wb_adr, wb_dat_o, wb_sel, wb_cyc, wb_stb, wb_we,
    input  wb_ack
  );

  modport slave (
    input  wb_adr, wb_dat_o, wb_sel, wb_cyc, wb_stb, wb_we,
    output wb_ack
  );
endinterface

// File: rtl/spi_rx_sync.sv
// Oversampling SPI mode-0 receiver: synchronizers, SCK edge detect, MSB-first shifter,
// and registered byte/frame-edge pulses in the system clock domain.
module spi_rx_sync
  import bk_pkg::*;
#(
  parameter int SYNC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       di,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       ss_fall,
  output logic       ss_rise
);

  logic [SYNC-1:0] sck_sr, ss_sr, di_sr;
  logic            sck_d, ss_d;
  logic [2:0]      bit_cnt;
  logic            sck_s, ss_s, di_s, sck_rise;

  assign sck_s    = sck_sr[SYNC-1];
  assign ss_s     = ss_sr[SYNC-1];
  assign di_s     = di_sr[SYNC-1];
  assign sck_rise = sck_s & ~sck_d;

  // SS chain resets to the inactive level so reset release never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sr     <= '0;
      ss_sr      <= '1;
      di_sr      <= '0;
      sck_d      <= 1'b0;
      ss_d       <= 1'b1;
      bit_cnt    <= 3'd0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      ss_fall    <= 1'b0;
      ss_rise    <= 1'b0;
    end else begin
      sck_sr     <= {sck_sr[SYNC-2:0], sck};
      ss_sr      <= {ss_sr[SYNC-2:0], ss_n};
      di_sr      <= {di_sr[SYNC-2:0], di};
      sck_d      <= sck_s;
      ss_d       <= ss_s;
      ss_fall    <= ~ss_s & ss_d;
      ss_rise    <= ss_s & ~ss_d;
      byte_valid <= 1'b0;
      if (ss_s) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        rx_byte <= {rx_byte[6:0], di_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_wb_loader.sv
// Host-to-Wishbone loader: parses SPI frames (cmd, address, payload) and issues one
// Wishbone write per completed word or byte, with ack timeout and overflow reporting.
module spi_wb_loader
  import bk_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int SYNC    = 2
) (
  input  logic            wb_clk,
  input  logic            sys_init_n,
  input  logic            SPI_SCK,
  input  logic            SPI_SS3,
  input  logic            SPI_DI,
  spi_wb_loader_if.master wb,
  output logic            busy,
  output logic            err,
  output logic [15:0]     wcount,
  output parse_state_e    parse_state,
  output bus_state_e      bus_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [7:0]    rx_byte;
  logic          byte_valid, ss_fall, ss_rise;
  parse_state_e  parse_q, parse_d;
  bus_state_e    bus_q, bus_d;
  logic          mode_word, half;
  logic [7:0]    adr_lo_q, lo_q;
  logic [15:0]   adr;
  logic          pend_vld, pend_word;
  logic [15:0]   pend_dat;
  logic [TW-1:0] tcnt;
  logic          req;
  logic [15:0]   req_dat;
  logic          issue, done_ack, done_to, ovf, adr_load;
  logic [15:0]   adr_q, dat_q;
  logic [1:0]    sel_q;

  spi_rx_sync #(.SYNC(SYNC)) u_rx (
    .clk        (wb_clk),
    .rst_n      (sys_init_n),
    .sck        (SPI_SCK),
    .ss_n       (SPI_SS3),
    .di         (SPI_DI),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .ss_fall    (ss_fall),
    .ss_rise    (ss_rise)
  );

  always_ff @(posedge wb_clk or negedge sys_init_n) begin
    if (!sys_init_n) parse_q <= S_IDLE;
    else             parse_q <= parse_d;
  end

  always_comb begin
    parse_d = parse_q;
    req     = 1'b0;
    req_dat = 16'h0000;
    case (parse_q)
      S_IDLE, S_SKIP: parse_d = parse_q;
      S_CMD: if (byte_valid)
        parse_d = (rx_byte == CMD_WR_WORD || rx_byte == CMD_WR_BYTE) ? S_ALO : S_SKIP;
      S_ALO: if (byte_valid) parse_d = S_AHI;
      S_AHI: if (byte_valid) parse_d = S_DATA;
      S_DATA: if (byte_valid) begin
        if (!mode_word) begin
          req     = 1'b1;
          req_dat = {rx_byte, rx_byte};
        end else if (half) begin
          req     = 1'b1;
          req_dat = {rx_byte, lo_q};
        end
      end
      default: parse_d = S_IDLE;
    endcase
    // Frame edges override everything; a frame end drops any half-built word.
    if (ss_rise) begin
      parse_d = S_IDLE;
      req     = 1'b0;
    end
    if (ss_fall) parse_d = S_CMD;
  end

  assign adr_load = (parse_q == S_AHI) && byte_valid && !ss_rise;

  always_ff @(posedge wb_clk or negedge sys_init_n) begin
    if (!sys_init_n) begin
      mode_word <= 1'b0;
      half      <= 1'b0;
      adr_lo_q  <= 8'h00;
      lo_q      <= 8'h00;
    end else begin
      if (ss_fall || ss_rise) begin
        half <= 1'b0;
      end else if (parse_q == S_DATA && byte_valid && mode_word) begin
        half <= ~half;
        if (!half) lo_q <= rx_byte;
      end
      if (parse_q == S_CMD && byte_valid) mode_word <= (rx_byte == CMD_WR_WORD);
      if (parse_q == S_ALO && byte_valid) adr_lo_q <= rx_byte;
    end
  end

  always_ff @(posedge wb_clk or negedge sys_init_n) begin
    if (!sys_init_n) bus_q <= B_IDLE;
    else             bus_q <= bus_d;
  end

  always_comb begin
    bus_d    = bus_q;
    issue    = 1'b0;
    done_ack = 1'b0;
    done_to  = 1'b0;
    case (bus_q)
      B_IDLE: if (pend_vld) begin
        bus_d = B_WAIT;
        issue = 1'b1;
      end
      B_WAIT: if (wb.wb_ack) begin
        bus_d    = B_IDLE;
        done_ack = 1'b1;
      end else if (tcnt == TW'(TIMEOUT - 1)) begin
        // Counter reaches TIMEOUT on this edge: abandon the cycle.
        bus_d   = B_IDLE;
        done_to = 1'b1;
      end
      default: bus_d = B_IDLE;
    endcase
  end

  // A request in the same cycle pend is consumed just refills it.
  assign ovf = req && pend_vld && !issue;

  always_ff @(posedge wb_clk or negedge sys_init_n) begin
    if (!sys_init_n) begin
      pend_vld  <= 1'b0;
      pend_word <= 1'b0;
      pend_dat  <= 16'h0000;
      adr       <= 16'h0000;
      adr_q     <= 16'h0000;
      dat_q     <= 16'h0000;
      sel_q     <= 2'b00;
      tcnt      <= '0;
      wcount    <= 16'h0000;
      err       <= 1'b0;
    end else begin
      if (req) begin
        pend_vld  <= 1'b1;
        pend_dat  <= req_dat;
        pend_word <= mode_word;
      end else if (issue) begin
        pend_vld <= 1'b0;
      end
      if (issue) begin
        adr_q <= adr;
        dat_q <= pend_dat;
        sel_q <= pend_word ? 2'b11 : (adr[0] ? 2'b10 : 2'b01);
        tcnt  <= '0;
      end else if (bus_q == B_WAIT) begin
        tcnt <= tcnt + TW'(1);
      end
      // Address advances on completion whether acked or dropped; word writes carry sel=11.
      if (adr_load)
        adr <= {rx_byte, adr_lo_q[7:1], adr_lo_q[0] & ~mode_word};
      else if (done_ack || done_to)
        adr <= adr + ((sel_q == 2'b11) ? 16'd2 : 16'd1);
      if (ss_fall)       wcount <= 16'h0000;
      else if (done_ack) wcount <= wcount + 16'd1;
      if (done_to || ovf) err <= 1'b1;
      else if (ss_fall)   err <= 1'b0;
    end
  end

  assign wb.wb_adr   = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel   = sel_q;
  assign wb.wb_cyc   = (bus_q == B_WAIT);
  assign wb.wb_stb   = (bus_q == B_WAIT);
  assign wb.wb_we    = (bus_q == B_WAIT);

  assign busy        = (parse_q != S_IDLE) || pend_vld || (bus_q != B_IDLE);
  assign parse_state = parse_q;
  assign bus_state   = bus_q;

endmodule

// File: tb/tb_spi_wb_loader.sv
// Bench for spi_wb_loader: SPI frame driver, Wishbone slave/monitor and a frame-level write model.
module tb_spi_wb_loader;
  import bk_pkg::*;

  localparam int TIMEOUT = 255;
  localparam int SYNC    = 2;

  logic         wb_clk, sys_init_n;
  logic         SPI_SCK, SPI_SS3, SPI_DI;
  logic         busy, err;
  logic [15:0]  wcount;
  parse_state_e parse_state;
  bus_state_e   bus_state;

  spi_wb_loader_if wb();

  spi_wb_loader #(.TIMEOUT(TIMEOUT), .SYNC(SYNC)) dut (
    .wb_clk      (wb_clk),
    .sys_init_n  (sys_init_n),
    .SPI_SCK     (SPI_SCK),
    .SPI_SS3     (SPI_SS3),
    .SPI_DI      (SPI_DI),
    .wb          (wb),
    .busy        (busy),
    .err         (err),
    .wcount      (wcount),
    .parse_state (parse_state),
    .bus_state   (bus_state)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_bit_cyc = 0;
  int          wr_seen = 0;
  int          ack_dly = 2;
  bit          ack_en = 1'b1;
  bit          lat_en = 1'b1;
  logic [33:0] exp_q[$];
  logic [7:0]  fb[$];

  // Clock and reset
  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  initial forever begin
    @(posedge wb_clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected writes of one frame from its full bytes.
  task automatic model_frame(output int nwr);
    logic [15:0] a;
    nwr = 0;
    if (fb.size() < 3) return;
    if (fb[0] == 8'h01) begin
      a = {fb[2], fb[1]} & 16'hFFFE;
      for (int i = 3; i + 1 < fb.size(); i += 2) begin
        exp_q.push_back({a, fb[i+1], fb[i], 2'b11});
        a = a + 16'd2;
        nwr++;
      end
    end else if (fb[0] == 8'h02) begin
      a = {fb[2], fb[1]};
      for (int i = 3; i < fb.size(); i++) begin
        exp_q.push_back({a, fb[i], fb[i], a[0] ? 2'b10 : 2'b01});
        a = a + 16'd1;
        nwr++;
      end
    end
  endtask

  // Driver tasks: SCK period 8 clocks, data changes while SCK is low.
  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      SPI_DI = b[i];
      repeat (4) @(posedge wb_clk);
      #1;
      SPI_SCK = 1'b1;
      last_bit_cyc = cyc;
      repeat (4) @(posedge wb_clk);
      #1;
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic send_frame(input int partial);
    @(posedge wb_clk);
    #1;
    SPI_SS3 = 1'b0;
    repeat (8) @(posedge wb_clk);
    #1;
    foreach (fb[i]) spi_bits(fb[i], 8);
    if (partial > 0) spi_bits(8'hA5, partial);
    repeat (4) @(posedge wb_clk);
    #1;
    SPI_SS3 = 1'b1;
    repeat (8) @(posedge wb_clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge wb_clk);
      n++;
    end
    chk("idle_reached", 64'(busy), 64'(0));
    repeat (2) @(posedge wb_clk);
    #1;
  endtask

  task automatic run_frame(input int partial, input bit busy_after_end);
    int nwr;
    wr_seen = 0;
    model_frame(nwr);
    send_frame(partial);
    if (busy_after_end) chk("busy_after_end", 64'(busy), 64'(1));
    wait_idle();
    chk("nwrites", 64'(wr_seen), 64'(nwr));
    chk("wcount", 64'(wcount), ack_en ? 64'(nwr) : 64'(0));
    chk("err", 64'(err), (!ack_en && nwr > 0) ? 64'(1) : 64'(0));
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic check_reset_state();
    chk("rst_cyc", 64'(wb.wb_cyc), 64'(0));
    chk("rst_stb", 64'(wb.wb_stb), 64'(0));
    chk("rst_we", 64'(wb.wb_we), 64'(0));
    chk("rst_adr", 64'(wb.wb_adr), 64'(0));
    chk("rst_dat", 64'(wb.wb_dat_o), 64'(0));
    chk("rst_sel", 64'(wb.wb_sel), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_wcount", 64'(wcount), 64'(0));
    chk("rst_pstate", 64'(parse_state), 64'(S_IDLE));
    chk("rst_bstate", 64'(bus_state), 64'(B_IDLE));
  endtask

  // Scoreboard and slave: pops the expected queue at each strobe start, acks after ack_dly.
  logic [33:0] mon_cap;
  bit          mon_prev_stb, mon_prev_ack;
  int          mon_cnt;
  initial begin
    wb.wb_ack    = 1'b0;
    mon_prev_stb = 1'b0;
    mon_prev_ack = 1'b0;
    mon_cnt      = 0;
    mon_cap      = '0;
    forever begin
      @(negedge wb_clk);
      if (!sys_init_n) begin
        wb.wb_ack    = 1'b0;
        mon_prev_stb = 1'b0;
        mon_prev_ack = 1'b0;
        mon_cnt      = 0;
      end else begin
        if (wb.wb_stb && !mon_prev_stb) begin
          wr_seen++;
          mon_cap = {wb.wb_adr, wb.wb_dat_o, wb.wb_sel};
          if (exp_q.size() > 0) chk("write", 64'(mon_cap), 64'(exp_q.pop_front()));
          chk("we_high", 64'(wb.wb_we), 64'(1));
          if (lat_en) chk("latency", 64'(cyc - last_bit_cyc), 64'(SYNC + 3));
        end
        if (wb.wb_stb) begin
          mon_cnt++;
          if (ack_en && mon_cnt == ack_dly) begin
            chk("hold", 64'({wb.wb_adr, wb.wb_dat_o, wb.wb_sel}), 64'(mon_cap));
            wb.wb_ack = 1'b1;
          end else begin
            wb.wb_ack = 1'b0;
          end
        end else begin
          if (mon_prev_stb && !mon_prev_ack) chk("timeout_len", 64'(mon_cnt), 64'(TIMEOUT));
          mon_cnt   = 0;
          wb.wb_ack = 1'b0;
        end
        mon_prev_stb = wb.wb_stb;
        mon_prev_ack = wb.wb_ack;
      end
    end
  end

  initial begin
    int r, len;
    logic [7:0] c;
    SPI_SCK    = 1'b0;
    SPI_SS3    = 1'b1;
    SPI_DI     = 1'b0;
    sys_init_n = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1;
    check_reset_state();
    sys_init_n = 1'b1;
    repeat (4) @(posedge wb_clk);
    #1;

    // Word frame
    ack_dly = 2;
    fb = {8'h01, 8'h00, 8'h40, 8'h34, 8'h12, 8'h78, 8'h56};
    run_frame(0, 1'b0);

    // Byte frame
    fb = {8'h02, 8'h01, 8'h40, 8'hAA, 8'hBB};
    run_frame(0, 1'b0);

    // Address wrap
    fb = {8'h01, 8'hFE, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(0, 1'b0);

    // Timeout on both words, then an empty frame clears err
    ack_en = 1'b0;
    lat_en = 1'b0;
    fb = {8'h01, 8'h10, 8'h20, 8'hC3, 8'h5A, 8'h0F, 8'hF0};
    run_frame(0, 1'b0);
    ack_en = 1'b1;
    lat_en = 1'b1;
    SPI_SS3 = 1'b0;
    repeat (8) @(posedge wb_clk);
    #1;
    chk("err_cleared", 64'(err), 64'(0));
    SPI_SS3 = 1'b1;
    repeat (8) @(posedge wb_clk);
    #1;

    // Frame ends after 1.5 words plus a partial byte
    fb = {8'h01, 8'h10, 8'h20, 8'h01, 8'h02, 8'h03};
    run_frame(4, 1'b0);

    // Write still in flight when the frame ends
    ack_dly = 30;
    fb = {8'h01, 8'h00, 8'h30, 8'hEF, 8'hBE};
    run_frame(0, 1'b1);
    ack_dly = 2;

    // Unknown command
    fb = {8'h07, 8'h00, 8'h40, 8'h12, 8'h34};
    run_frame(0, 1'b0);

    // Randomized frames
    for (int f = 0; f < 14; f++) begin
      r = $urandom_range(0, 5);
      if (r < 2)      c = 8'h01;
      else if (r < 4) c = 8'h02;
      else begin
        c = 8'($urandom_range(3, 255));
      end
      fb.delete();
      fb.push_back(c);
      fb.push_back(8'($urandom_range(0, 255)));
      fb.push_back(8'($urandom_range(0, 255)));
      len = $urandom_range(0, 5);
      for (int i = 0; i < len; i++) fb.push_back(8'($urandom_range(0, 255)));
      ack_dly = $urandom_range(1, 4);
      run_frame(0, 1'b0);
    end
    ack_dly = 2;

    // Asynchronous reset while a cycle waits for ack
    ack_en = 1'b0;
    fb = {8'h01, 8'h00, 8'h50, 8'h11, 8'h22};
    begin
      int nwr;
      wr_seen = 0;
      model_frame(nwr);
      send_frame(0);
    end
    chk("stb_before_reset", 64'(wb.wb_stb), 64'(1));
    sys_init_n = 1'b0;
    #1;
    check_reset_state();
    exp_q.delete();
    repeat (3) @(posedge wb_clk);
    #1;
    sys_init_n = 1'b1;
    ack_en = 1'b1;
    repeat (4) @(posedge wb_clk);
    #1;
    fb = {8'h01, 8'h22, 8'h60, 8'h9A, 8'h78};
    run_frame(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
